// File: rtl/hilo_div_ctrl_if.sv
// Bundle of the request handshake, divider sequencing lines and HI/LO results
// exchanged between a requester and hilo_div_ctrl.
interface hilo_div_ctrl_if;
   // Handshake: a request transfers on a rising edge where req_valid and
   // req_ready are both high; req_ready depends only on controller state.
   logic        req_valid;
   logic        req_ready;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [5:0]  div_signal;
   logic        div_reset;
   logic [31:0] div_dividend;
   logic [31:0] div_divisor;
   logic [63:0] div_dataout;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        done;
   logic        dz;

   modport master (
      output req_valid, dividend, divisor, div_dataout,
      input  req_ready, div_signal, div_reset, div_dividend, div_divisor,
             hi, lo, done, dz
   );

   modport slave (
      input  req_valid, dividend, divisor, div_dataout,
      output req_ready, div_signal, div_reset, div_dividend, div_divisor,
             hi, lo, done, dz
   );
endinterface

// File: rtl/hilo_div_ctrl.sv
// Sequences an iterative unsigned divider (clear, ITER iterate cycles, publish)
// and captures quotient/remainder into LO/HI; divide-by-zero is short-circuited.
module hilo_div_ctrl #(
   parameter logic [5:0] DIVU = 6'b011011,
   parameter logic [5:0] OUT  = 6'b111111,
   parameter logic [5:0] NOP  = 6'b000000,
   parameter int         ITER = 32
) (
   input  logic            clk,
   input  logic            reset,
   hilo_div_ctrl_if.slave  bus,
   output logic [2:0]      dbg_state_o
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_CLR  = 3'd1;
   localparam logic [2:0] S_RUN  = 3'd2;
   localparam logic [2:0] S_OUTC = 3'd3;
   localparam logic [2:0] S_CAPT = 3'd4;
   localparam logic [2:0] S_DZ   = 3'd5;

   localparam logic [5:0] LAST = 6'(ITER - 1);

   logic [2:0]  state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] dvd_q, dvd_d;
   logic [31:0] dvs_q, dvs_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        done_q, done_d;
   logic        dz_q, dz_d;
   logic [5:0]  sig_q, sig_d;
   logic        drst_q, drst_d;
   logic        ready_q, ready_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      dz_d    = dz_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid && ready_q) begin
               dvd_d   = bus.dividend;
               dvs_d   = bus.divisor;
               state_d = (bus.divisor == 32'd0) ? S_DZ : S_CLR;
            end
         end
         S_CLR: begin
            cnt_d   = 6'd0;
            state_d = S_RUN;
         end
         S_RUN: begin
            if (cnt_q == LAST) begin
               cnt_d   = 6'd0;
               state_d = S_OUTC;
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end
         S_OUTC: state_d = S_CAPT;
         S_CAPT: begin
            lo_d    = bus.div_dataout[63:32];
            hi_d    = bus.div_dataout[31:0];
            done_d  = 1'b1;
            dz_d    = 1'b0;
            state_d = S_IDLE;
         end
         S_DZ: begin
            hi_d    = dvd_q;
            lo_d    = 32'hFFFF_FFFF;
            done_d  = 1'b1;
            dz_d    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Divider controls are decoded from the next state so they stay registered
   // yet line up with the state they belong to.
   always_comb begin
      sig_d   = NOP;
      if (state_d == S_RUN)  sig_d = DIVU;
      if (state_d == S_OUTC) sig_d = OUT;
      drst_d  = (state_d == S_IDLE) || (state_d == S_CLR) || (state_d == S_DZ);
      ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 6'd0;
         dvd_q   <= 32'd0;
         dvs_q   <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
         sig_q   <= NOP;
         drst_q  <= 1'b1;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
         sig_q   <= sig_d;
         drst_q  <= drst_d;
         ready_q <= ready_d;
      end
   end

   assign bus.req_ready    = ready_q;
   assign bus.div_signal   = sig_q;
   assign bus.div_reset    = drst_q;
   assign bus.div_dividend = dvd_q;
   assign bus.div_divisor  = dvs_q;
   assign bus.hi           = hi_q;
   assign bus.lo           = lo_q;
   assign bus.done         = done_q;
   assign bus.dz           = dz_q;
   assign dbg_state_o      = state_q;

endmodule

// File: doc/hilo_div_ctrl.md
HILO_DIV_CTRL -- requirements
Module: hilo_div_ctrl

Interface
REQ-001 Parameter DIVU, default 6'b011011, divider iterate code.
REQ-002 Parameter OUT, default 6'b111111, divider result-publish code.
REQ-003 Parameter NOP, default 6'b000000, divider idle code.
REQ-004 Parameter ITER, default 32, number of DIVU cycles per operation.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low; low clears all state immediately.
REQ-007 req_valid  in  1  divide request.
REQ-008 req_ready  out  1  high when a request can be accepted.
REQ-009 dividend  in  32  unsigned dividend, sampled at acceptance.
REQ-010 divisor  in  32  unsigned divisor, sampled at acceptance.
REQ-011 div_signal  out  6  operation code to the divider (NOP/DIVU/OUT).
REQ-012 div_reset  out  1  active-high clear to the divider.
REQ-013 div_dividend  out  32  registered dividend held for the whole operation.
REQ-014 div_divisor  out  32  registered divisor held for the whole operation.
REQ-015 div_dataout  in  64  divider result: [63:32] quotient, [31:0] remainder.
REQ-016 hi  out  32  remainder register.
REQ-017 lo  out  32  quotient register.
REQ-018 done  out  1  one-cycle pulse: hi/lo just updated.
REQ-019 dz  out  1  set with done when the divisor was zero; otherwise cleared with done.

Function
REQ-020 States SHALL be IDLE, CLR, RUN, OUTC, CAPT, DZ; all outputs SHALL be registered.
REQ-021 Acceptance SHALL occur at a rising edge where req_valid and req_ready are both high; req_ready SHALL equal (state==IDLE).
REQ-022 On acceptance, the block SHALL register the operands into div_dividend/div_divisor; next state SHALL be DZ if divisor==0, else CLR.
REQ-023 CLR SHALL last 1 cycle with div_reset=1 and div_signal=NOP, then go to RUN with the iteration counter at 0.
REQ-024 RUN SHALL drive div_signal=DIVU and div_reset=0 for exactly ITER cycles using a 6-bit counter 0..ITER-1, then go to OUTC.
REQ-025 OUTC SHALL drive div_signal=OUT for 1 cycle, then go to CAPT.
REQ-026 CAPT SHALL drive div_signal=NOP; at its closing edge lo<=div_dataout[63:32], hi<=div_dataout[31:0], done<=1, dz<=0; next state SHALL be IDLE.
REQ-027 DZ SHALL last 1 cycle; at its closing edge hi<=div_dividend, lo<=32'hFFFFFFFF, done<=1, dz<=1; next state SHALL be IDLE; the divider SHALL NOT be sequenced.
REQ-028 Latency: with acceptance at edge E0, hi/lo/done SHALL update at E35 (nonzero divisor) or E1 (zero divisor).
REQ-029 done SHALL be high for exactly one cycle; dz SHALL hold its value until the next done.
REQ-030 hi/lo SHALL hold their values between completions.
REQ-031 IDLE SHALL drive div_reset=1 and div_signal=NOP.
REQ-032 While busy, req_valid SHALL be ignored with no queuing; a request is accepted during the done cycle, since the state is IDLE then.
REQ-033 Operand inputs changing after acceptance SHALL NOT affect the result.

Reset
REQ-034 reset low SHALL immediately force state=IDLE, counter=0, hi=0, lo=0, done=0, dz=0, div_dividend=0, div_divisor=0, div_signal=NOP, div_reset=1, req_ready=1.
REQ-035 Reset asserted mid-operation SHALL abort it with no done pulse; the first request after release SHALL complete correctly.

Verification
REQ-036 100/7 accepted at E0 -> RUN for 32 DIVU cycles, then 1 OUT; at E35 lo=14, hi=2, done=1 for 1 cycle, dz=0.
REQ-037 0xFFFFFFFF/1 -> lo=0xFFFFFFFF, hi=0; 3/10 -> lo=0, hi=3.
REQ-038 5/0 -> div_signal stays NOP; at E1 hi=5, lo=0xFFFFFFFF, done=1, dz=1; the next valid divide clears dz.
REQ-039 reset pulsed low at RUN count 10 -> hi=lo=0, div_reset=1, no done; then 9/3 -> lo=3, hi=0 at E35.
REQ-040 req_valid held high with operands 20/6 then 50/8 -> first result (3,2) is accepted; second is accepted at the done-cycle edge and completes 35 edges later (6,2); no requests are accepted while busy.
